// File: rtl/ex_ctrl_pkg.sv
// Shared encodings, FSM state type and latency defaults for the EX-stage
// hazard/forwarding controller.
package ex_ctrl_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    localparam int unsigned MULT_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF  = 32;
    localparam int unsigned RA_W_DEF     = 5;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_DONE
    } md_state_t;

    // The younger result (EX/MEM) always wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit)
            return FWD_EXMEM;
        else if (memwb_hit)
            return FWD_MEMWB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/md_seq.sv
// MULT/DIV unit sequencer: IDLE/RUN/DONE FSM with a latency down-counter.
// md_busy and md_done are registered copies of the next state.
module md_seq
    import ex_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      start,
    input  logic      is_div,
    output md_state_t state,
    output logic      md_busy,
    output logic      md_done
);

    localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MULT_RELOAD = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_RELOAD  = CNT_W'(DIV_LAT - 1);

    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] reload;

    // A start during RUN cannot happen (decode is stalled), so it is ignored there.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        reload    = is_div ? DIV_RELOAD : MULT_RELOAD;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_RUN;
                    cnt_nxt   = reload;
                end
            end
            MD_RUN: begin
                if (cnt == '0)
                    state_nxt = MD_DONE;
                else
                    cnt_nxt = cnt - CNT_W'(1);
            end
            MD_DONE: begin
                if (start) begin
                    state_nxt = MD_RUN;
                    cnt_nxt   = reload;
                end else begin
                    state_nxt = MD_IDLE;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MD_IDLE;
            cnt     <= '0;
            md_busy <= 1'b0;
            md_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            md_busy <= (state_nxt == MD_RUN);
            md_done <= (state_nxt == MD_DONE);
        end
    end

endmodule

// File: rtl/ex_hazard_scheduler.sv
// EX-stage controller: operand forwarding selects, load-use and HI/LO
// hazard stall, and sequencing of the multi-cycle MULT/DIV unit.
module ex_hazard_scheduler
    import ex_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    parameter int unsigned RA_W     = RA_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [RA_W-1:0] IF_ID_rs,
    input  logic [RA_W-1:0] IF_ID_rt,
    input  logic            IF_ID_uses_hilo,
    input  logic            IF_ID_md_op,
    input  logic [RA_W-1:0] ID_EX_rs,
    input  logic [RA_W-1:0] ID_EX_rt,
    input  logic            ID_EX_mem_read,
    input  logic            ID_EX_md_start,
    input  logic            ID_EX_md_is_div,
    input  logic            EX_MEM_reg_write,
    input  logic [RA_W-1:0] EX_MEM_rd,
    input  logic            MEM_WB_reg_write,
    input  logic [RA_W-1:0] MEM_WB_rd,
    output logic [1:0]      ForwardA,
    output logic [1:0]      ForwardB,
    output logic            stall,
    output logic            md_busy,
    output logic            md_done
);

    md_state_t md_state;
    logic      exmem_live;
    logic      memwb_live;
    logic      load_use;
    logic      md_hazard;

    md_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_seq (
        .clk     (clk),
        .reset   (reset),
        .start   (ID_EX_md_start),
        .is_div  (ID_EX_md_is_div),
        .state   (md_state),
        .md_busy (md_busy),
        .md_done (md_done)
    );

    // Writes to $0 are discarded, so they never forward.
    always_comb begin
        exmem_live = EX_MEM_reg_write && (EX_MEM_rd != '0);
        memwb_live = MEM_WB_reg_write && (MEM_WB_rd != '0);
        ForwardA   = FWD_REG;
        ForwardB   = FWD_REG;
        if (!reset) begin
            ForwardA = fwd_sel(exmem_live && (EX_MEM_rd == ID_EX_rs),
                               memwb_live && (MEM_WB_rd == ID_EX_rs));
            ForwardB = fwd_sel(exmem_live && (EX_MEM_rd == ID_EX_rt),
                               memwb_live && (MEM_WB_rd == ID_EX_rt));
        end
    end

    // A HI/LO reader or a new MD op waits while the unit runs or is being started;
    // in DONE the result lands in HI/LO before the reader reaches EX.
    always_comb begin
        load_use  = ID_EX_mem_read && (ID_EX_rt != '0) &&
                    ((ID_EX_rt == IF_ID_rs) || (ID_EX_rt == IF_ID_rt));
        md_hazard = (IF_ID_uses_hilo || IF_ID_md_op) &&
                    ((md_state == MD_RUN) || ID_EX_md_start);
        stall     = !reset && (load_use || md_hazard);
    end

endmodule

// File: tb/tb_ex_hazard_scheduler.sv
// Directed scoreboard bench for ex_hazard_scheduler: expected output vectors
// are queued as each step is driven and popped when the DUT output is sampled.
module tb_ex_hazard_scheduler;

    logic       clk;
    logic       reset;
    logic [4:0] IF_ID_rs;
    logic [4:0] IF_ID_rt;
    logic       IF_ID_uses_hilo;
    logic       IF_ID_md_op;
    logic [4:0] ID_EX_rs;
    logic [4:0] ID_EX_rt;
    logic       ID_EX_mem_read;
    logic       ID_EX_md_start;
    logic       ID_EX_md_is_div;
    logic       EX_MEM_reg_write;
    logic [4:0] EX_MEM_rd;
    logic       MEM_WB_reg_write;
    logic [4:0] MEM_WB_rd;
    logic [1:0] ForwardA;
    logic [1:0] ForwardB;
    logic       stall;
    logic       md_busy;
    logic       md_done;

    typedef struct {
        string      tag;
        logic [6:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    ex_hazard_scheduler #(
        .MULT_LAT (4),
        .DIV_LAT  (32),
        .RA_W     (5)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .IF_ID_rs         (IF_ID_rs),
        .IF_ID_rt         (IF_ID_rt),
        .IF_ID_uses_hilo  (IF_ID_uses_hilo),
        .IF_ID_md_op      (IF_ID_md_op),
        .ID_EX_rs         (ID_EX_rs),
        .ID_EX_rt         (ID_EX_rt),
        .ID_EX_mem_read   (ID_EX_mem_read),
        .ID_EX_md_start   (ID_EX_md_start),
        .ID_EX_md_is_div  (ID_EX_md_is_div),
        .EX_MEM_reg_write (EX_MEM_reg_write),
        .EX_MEM_rd        (EX_MEM_rd),
        .MEM_WB_reg_write (MEM_WB_reg_write),
        .MEM_WB_rd        (MEM_WB_rd),
        .ForwardA         (ForwardA),
        .ForwardB         (ForwardB),
        .stall            (stall),
        .md_busy          (md_busy),
        .md_done          (md_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        IF_ID_rs         = '0;
        IF_ID_rt         = '0;
        IF_ID_uses_hilo  = 1'b0;
        IF_ID_md_op      = 1'b0;
        ID_EX_rs         = '0;
        ID_EX_rt         = '0;
        ID_EX_mem_read   = 1'b0;
        ID_EX_md_start   = 1'b0;
        ID_EX_md_is_div  = 1'b0;
        EX_MEM_reg_write = 1'b0;
        EX_MEM_rd        = '0;
        MEM_WB_reg_write = 1'b0;
        MEM_WB_rd        = '0;
    endtask

    // Queue the expected vector, let combinational outputs settle, then pop and compare.
    task automatic check(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                         input logic st, input logic bz, input logic dn);
        exp_t       e;
        logic [6:0] obs;
        logic       proto;
        sb.push_back('{tag: tag, val: {fa, fb, st, bz, dn}});
        #1;
        obs   = {ForwardA, ForwardB, stall, md_busy, md_done};
        proto = ID_EX_md_start && md_busy;
        e     = sb.pop_front();
        vectors++;
        assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed {fa,fb,stall,busy,done}=%b expected=%b", e.tag, obs, e.val);
        end
        vectors++;
        assert (proto === 1'b0) else begin
            miscompares++;
            $error("FAIL %s_md_start_in_run observed=%b expected=0", e.tag, proto);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clr();
        reset = 1'b1;
        tick();
        tick();
        // Hazard-looking inputs while in reset must be masked.
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd5; ID_EX_rs = 5'd5;
        ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
        check("reset_mask", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        clr();
        check("idle_after_reset", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Forwarding priority and $0 handling.
        tick();
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd5;
        MEM_WB_reg_write = 1'b1; MEM_WB_rd = 5'd5;
        ID_EX_rs = 5'd5;
        check("fwdA_exmem_wins", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);
        EX_MEM_reg_write = 1'b0;
        check("fwdA_memwb_only", 2'b01, 2'b00, 1'b0, 1'b0, 1'b0);
        ID_EX_rt = 5'd5;
        check("fwdAB_memwb", 2'b01, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        clr();
        MEM_WB_reg_write = 1'b1; MEM_WB_rd = 5'd7; ID_EX_rt = 5'd7;
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd3;
        check("fwdB_memwb", 2'b00, 2'b01, 1'b0, 1'b0, 1'b0);
        MEM_WB_rd = 5'd0; ID_EX_rt = 5'd0;
        check("fwdB_rd0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        EX_MEM_rd = 5'd0; ID_EX_rs = 5'd0;
        check("fwdA_exmem_rd0", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        EX_MEM_rd = 5'd9; ID_EX_rs = 5'd9; EX_MEM_reg_write = 1'b0;
        check("fwdA_no_we", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Load-use: one stall cycle, then the bubble clears mem_read.
        tick();
        clr();
        ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8;
        check("lu_rs_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        ID_EX_mem_read = 1'b0; ID_EX_rt = 5'd0;
        check("lu_bubble_release", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd12; IF_ID_rs = 5'd1; IF_ID_rt = 5'd12;
        check("lu_rt_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        ID_EX_rt = 5'd0; IF_ID_rs = 5'd0; IF_ID_rt = 5'd0;
        check("lu_r0_no_stall", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // MULT: mfhi in decode stalls from the start cycle through RUN.
        tick();
        clr();
        ID_EX_md_start = 1'b1; ID_EX_md_is_div = 1'b0; IF_ID_uses_hilo = 1'b1;
        check("mult_start_stall", 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        ID_EX_md_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mult_run", 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
            tick();
        end
        check("mult_done", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        IF_ID_uses_hilo = 1'b0;
        check("mult_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // DIV then a back-to-back DIV started in DONE.
        ID_EX_md_start = 1'b1; ID_EX_md_is_div = 1'b1;
        check("div1_start_no_reader", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        ID_EX_md_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("div1_run", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            tick();
        end
        ID_EX_md_start = 1'b1; ID_EX_md_is_div = 1'b1;
        check("div1_done_restart", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        ID_EX_md_start = 1'b0; IF_ID_md_op = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("div2_run", 2'b00, 2'b00, 1'b1, 1'b1, 1'b0);
            tick();
        end
        check("div2_done", 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        IF_ID_md_op = 1'b0;
        check("div2_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset part-way through a DIV aborts it with no done pulse.
        ID_EX_md_start = 1'b1; ID_EX_md_is_div = 1'b1;
        check("div3_start", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        tick();
        ID_EX_md_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("div3_run", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
            tick();
        end
        reset = 1'b1;
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd5; ID_EX_rs = 5'd5;
        ID_EX_mem_read = 1'b1; ID_EX_rt = 5'd8; IF_ID_rs = 5'd8; IF_ID_uses_hilo = 1'b1;
        check("div3_reset_comb", 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        check("div3_reset_idle", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        clr();
        for (int i = 0; i < 25; i++) begin
            tick();
            check("div3_no_done", 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        EX_MEM_reg_write = 1'b1; EX_MEM_rd = 5'd5; ID_EX_rs = 5'd5;
        check("fwd_after_reset", 2'b10, 2'b00, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
